// File: rtl/ahb_fir_pkg.sv
// Shared constants and state type for the AHB-lite FIR register-map master.
// Addresses are byte offsets into the FIR slave's halfword register file.
package ahb_fir_pkg;

   localparam logic [3:0] ADDR_STATUS    = 4'h0;
   localparam logic [3:0] ADDR_RESULT    = 4'h2;
   localparam logic [3:0] ADDR_SAMPLE    = 4'h4;
   localparam logic [3:0] ADDR_COEFF0    = 4'h6;
   localparam logic [3:0] ADDR_COEFF1    = 4'h8;
   localparam logic [3:0] ADDR_COEFF2    = 4'hA;
   localparam logic [3:0] ADDR_COEFF3    = 4'hC;
   localparam logic [3:0] ADDR_NEW_COEFF = 4'hE;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic HSIZE_HALF = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_C_WR,
      ST_C_CONF,
      ST_C_POLL,
      ST_S_WR,
      ST_S_POLL,
      ST_S_RD
   } state_e;

   function automatic logic [3:0] coeff_addr(input logic [1:0] idx);
      return ADDR_COEFF0 + {1'b0, idx, 1'b0};
   endfunction

endpackage

// File: rtl/ahb_lite_fir_master.sv
// AHB-lite manager that loads FIR coefficients, streams samples and returns results.
// Define AHB_MASTER_POLL_TIMEOUT_EN to bound poll loops by POLL_MAX reads.
module ahb_lite_fir_master #(
  parameter int unsigned POLL_MAX = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        coeff_start,
  input  logic [63:0] coeffs,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  output logic        result_valid,
  output logic [15:0] result_data,
  output logic        result_err,
  output logic        busy,
  output logic        bus_err,
  output logic        timeout,
  output logic        hsel,
  output logic [3:0]  haddr,
  output logic        hsize,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [15:0] hwdata,
  input  logic [15:0] hrdata,
  input  logic        hresp
);

  import ahb_fir_pkg::*;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ph_q, ph_d;
  logic [63:0] coeff_q, coeff_d;
  logic [15:0] smp_q, smp_d;
  logic        dp_vld_q, dp_vld_d;
  logic        dp_wr_q, dp_wr_d;
  logic [15:0] dp_wdata_q, dp_wdata_d;
  logic        res_vld_q, res_vld_d;
  logic [15:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  logic        bus_err_q, bus_err_d;
  logic        arm_q, arm_d;

  logic        ap_en;
  logic        ap_wr;
  logic [3:0]  ap_addr;
  logic [15:0] ap_wdata;
  logic        poll_done;

`ifdef AHB_MASTER_POLL_TIMEOUT_EN
  localparam logic [7:0] POLL_LIM = 8'(POLL_MAX);
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic        tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    coeff_d    = coeff_q;
    smp_d      = smp_q;
    dp_vld_d   = 1'b0;
    dp_wr_d    = 1'b0;
    dp_wdata_d = '0;
    res_vld_d  = 1'b0;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    bus_err_d  = 1'b0;
    arm_d      = 1'b1;
    ap_en      = 1'b0;
    ap_wr      = 1'b0;
    ap_addr    = '0;
    ap_wdata   = '0;
    poll_done  = 1'b0;
`ifdef AHB_MASTER_POLL_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
    tmo_d      = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (arm_q && coeff_start) begin
          coeff_d = coeffs;
          cnt_d   = 2'd0;
          state_d = ST_C_WR;
        end else if (arm_q && sample_valid) begin
          smp_d   = sample_data;
          state_d = ST_S_WR;
        end
      end
      ST_C_WR: begin
        ap_en    = 1'b1;
        ap_wr    = 1'b1;
        ap_addr  = coeff_addr(cnt_q);
        ap_wdata = coeff_q[{cnt_q, 4'b0000} +: 16];
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ST_C_CONF;
        end
      end
      ST_C_CONF: begin
        ap_en    = 1'b1;
        ap_wr    = 1'b1;
        ap_addr  = ADDR_NEW_COEFF;
        ap_wdata = 16'h0001;
        ph_d     = 1'b1;
        state_d  = ST_C_POLL;
`ifdef AHB_MASTER_POLL_TIMEOUT_EN
        poll_cnt_d = '0;
`endif
      end
      ST_C_POLL, ST_S_POLL: begin
        if (!ph_q) begin
          ap_en   = 1'b1;
          ap_addr = (state_q == ST_C_POLL) ? ADDR_NEW_COEFF
                                           : ADDR_STATUS;
          ph_d    = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (dp_vld_q && !dp_wr_q) begin
            poll_done = (state_q == ST_C_POLL) ? (hrdata == 16'h0)
                                               : !hrdata[0];
            if (poll_done) begin
              if (state_q == ST_C_POLL) begin
                state_d = ST_IDLE;
              end else begin
                res_err_d = hrdata[8];
                state_d   = ST_S_RD;
              end
            end
`ifdef AHB_MASTER_POLL_TIMEOUT_EN
            else begin
              poll_cnt_d = poll_cnt_q + 8'd1;
              if (poll_cnt_d == POLL_LIM) begin
                tmo_d   = 1'b1;
                state_d = ST_IDLE;
              end
            end
`endif
          end
        end
      end
      ST_S_WR: begin
        ap_en    = 1'b1;
        ap_wr    = 1'b1;
        ap_addr  = ADDR_SAMPLE;
        ap_wdata = smp_q;
        ph_d     = 1'b1;
        state_d  = ST_S_POLL;
`ifdef AHB_MASTER_POLL_TIMEOUT_EN
        poll_cnt_d = '0;
`endif
      end
      ST_S_RD: begin
        if (!ph_q) begin
          ap_en   = 1'b1;
          ap_addr = ADDR_RESULT;
          ph_d    = 1'b1;
        end else begin
          ph_d       = 1'b0;
          res_vld_d  = 1'b1;
          res_data_d = hrdata;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ap_en) begin
      dp_vld_d   = 1'b1;
      dp_wr_d    = ap_wr;
      dp_wdata_d = ap_wr ? ap_wdata : 16'h0;
    end

    if (dp_vld_q && hresp) begin
      state_d    = ST_IDLE;
      ph_d       = 1'b0;
      dp_vld_d   = 1'b0;
      dp_wr_d    = 1'b0;
      dp_wdata_d = '0;
      res_vld_d  = 1'b0;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      bus_err_d  = 1'b1;
`ifdef AHB_MASTER_POLL_TIMEOUT_EN
      tmo_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ph_q       <= 1'b0;
      coeff_q    <= '0;
      smp_q      <= '0;
      dp_vld_q   <= 1'b0;
      dp_wr_q    <= 1'b0;
      dp_wdata_q <= '0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      coeff_q    <= coeff_d;
      smp_q      <= smp_d;
      dp_vld_q   <= dp_vld_d;
      dp_wr_q    <= dp_wr_d;
      dp_wdata_q <= dp_wdata_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      bus_err_q  <= bus_err_d;
      arm_q      <= arm_d;
    end
  end

`ifdef AHB_MASTER_POLL_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      poll_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign hsel         = ap_en;
  assign htrans       = ap_en ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr        = ap_addr;
  assign hwrite       = ap_en & ap_wr;
  assign hsize        = ap_en ? HSIZE_HALF : 1'b0;
  assign hwdata       = dp_wdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign sample_ready = (state_q == ST_IDLE) & arm_q & ~coeff_start;
  assign result_valid = res_vld_q;
  assign result_data  = res_data_q;
  assign result_err   = res_err_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_ahb_lite_fir_master.sv
// Randomised scoreboard bench for ahb_lite_fir_master with a behavioural FIR slave.
// Expected bus transfers and result events are queued by stimulus and popped by a monitor.
module tb_ahb_lite_fir_master;

  import ahb_fir_pkg::*;

`ifdef AHB_MASTER_POLL_TIMEOUT_EN
  localparam int PM = 4;
`else
  localparam int PM = 255;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        coeff_start = 1'b0;
  logic [63:0] coeffs = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_ready;
  logic        result_valid;
  logic [15:0] result_data;
  logic        result_err;
  logic        busy;
  logic        bus_err;
  logic        timeout;
  logic        hsel;
  logic [3:0]  haddr;
  logic        hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [15:0] hwdata;
  logic [15:0] hrdata = '0;
  logic        hresp = 1'b0;

  always #5 clk = ~clk;

  ahb_lite_fir_master #(.POLL_MAX(PM)) dut (
    .clk(clk), .n_rst(n_rst),
    .coeff_start(coeff_start), .coeffs(coeffs),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready),
    .result_valid(result_valid), .result_data(result_data),
    .result_err(result_err), .busy(busy),
    .bus_err(bus_err), .timeout(timeout),
    .hsel(hsel), .haddr(haddr), .hsize(hsize),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata), .hresp(hresp)
  );

  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    bit          chk;
    int          cyc;
  } xfer_t;

  typedef struct {
    int          kind;
    logic [15:0] data;
    logic        err;
    int          cyc;
  } ev_t;

  xfer_t exp_x[$];
  ev_t   exp_ev[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    sb_off = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok,
                     input longint act, input longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, expv, cyc);
    end
  endtask

  int          tot = 0;
  int          err_at = -1;
  int          ce_left = 0;
  int          st_left = 0;
  logic        st_err = 1'b0;
  logic [15:0] res_val = '0;

  always @(posedge clk) begin
    if (hsel && htrans == HTRANS_NONSEQ) begin
      hresp <= (tot == err_at);
      if (hwrite) begin
        hrdata <= 16'($urandom);
      end else begin
        case (haddr)
          ADDR_NEW_COEFF: begin
            hrdata <= (ce_left > 0) ? 16'h0001 : 16'h0000;
            if (ce_left > 0) ce_left--;
          end
          ADDR_STATUS: begin
            hrdata <= {7'b0, st_err, 7'b0, (st_left > 0)};
            if (st_left > 0) st_left--;
          end
          ADDR_RESULT: hrdata <= res_val;
          default:     hrdata <= 16'hDEAD;
        endcase
      end
      tot++;
    end else begin
      hresp  <= 1'b0;
      hrdata <= 16'($urandom);
    end
  end

  bit    pv = 1'b0;
  xfer_t pend;
  xfer_t ex;
  ev_t   ev;
  int    kind;

  always @(negedge clk) begin
    if (!n_rst) begin
      pv = 1'b0;
    end else begin
      chk("bus_idle_rules",
          (hsel == (htrans == HTRANS_NONSEQ)) &&
          (hsel ? (hsize == 1'b1)
                : (haddr == 4'h0 && !hwrite && !hsize)),
          {hsel, htrans, haddr, hwrite, hsize}, 0);
      if (pv && !sb_off) begin
        if (exp_x.size() == 0) begin
          chk("xfer_unexpected", 1'b0, {pend.wr, pend.addr}, 0);
        end else begin
          ex = exp_x.pop_front();
          chk("xfer_addr", pend.addr == ex.addr, pend.addr, ex.addr);
          chk("xfer_write", pend.wr == ex.wr, pend.wr, ex.wr);
          chk("xfer_cycle", pend.cyc == ex.cyc, pend.cyc, ex.cyc);
          if (ex.wr && ex.chk)
            chk("xfer_wdata", hwdata == ex.wdata, hwdata, ex.wdata);
        end
      end
      pv = 1'b0;
      if (hsel && htrans == HTRANS_NONSEQ) begin
        pend.addr = haddr;
        pend.wr   = hwrite;
        pend.cyc  = cyc;
        pv        = 1'b1;
      end
      if (!sb_off && (result_valid || bus_err || timeout)) begin
        kind = result_valid ? 0 : (bus_err ? 1 : 2);
        chk("event_single",
            (32'(result_valid) + 32'(bus_err) + 32'(timeout)) == 1,
            {result_valid, bus_err, timeout}, 0);
        if (exp_ev.size() == 0) begin
          chk("event_unexpected", 1'b0, kind, 0);
        end else begin
          ev = exp_ev.pop_front();
          chk("event_kind", kind == ev.kind, kind, ev.kind);
          chk("event_cycle", cyc == ev.cyc, cyc, ev.cyc);
          if (ev.kind == 0) begin
            chk("result_data", result_data == ev.data,
                result_data, ev.data);
            chk("result_err", result_err == ev.err,
                result_err, ev.err);
          end
        end
      end
    end
  end

  task automatic finish_seq(input xfer_t seq[$], input int e,
                            input ev_t ok_ev, input bit has_ev,
                            input int ok_end, output int end_c);
    xfer_t x;
    int    t;
    if (e < 0) begin
      foreach (seq[i]) exp_x.push_back(seq[i]);
      if (has_ev) exp_ev.push_back(ok_ev);
      end_c = ok_end;
    end else begin
      t = seq[e].cyc;
      foreach (seq[i]) begin
        if (seq[i].cyc <= t + 1) begin
          x = seq[i];
          if (x.cyc == t + 1) x.chk = 1'b0;
          exp_x.push_back(x);
        end
      end
      exp_ev.push_back('{1, 16'h0, 1'b0, t + 2});
      end_c = t + 2;
    end
  endtask

  task automatic wait_idle(input int exp_end, input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk(nm, done && cyc == exp_end, done ? cyc : -1, exp_end);
  endtask

  task automatic run_coeff(input logic [63:0] c, input int k,
                           input int e, input bit with_s,
                           output int end_c);
    xfer_t seq[$];
    int    s, nr, last;
    bit    to;
    ce_left = k;
    err_at  = (e < 0) ? -1 : tot + e;
    @(posedge clk); #1;
    coeffs      = c;
    coeff_start = 1'b1;
    if (with_s) sample_valid = 1'b1;
    @(negedge clk);
    s = cyc;
    if (with_s) chk("ready_blocked_by_coeff", sample_ready == 1'b0,
                    sample_ready, 0);
    for (int i = 0; i < 4; i++)
      seq.push_back('{ADDR_COEFF0 + 4'(2 * i), 1'b1,
                      c[16 * i +: 16], 1'b1, s + 1 + i});
    seq.push_back('{ADDR_NEW_COEFF, 1'b1, 16'h0001, 1'b1, s + 5});
    nr = k + 1;
    to = 1'b0;
`ifdef AHB_MASTER_POLL_TIMEOUT_EN
    if (k >= PM) begin
      nr = PM;
      to = 1'b1;
    end
`endif
    for (int i = 0; i < nr; i++)
      seq.push_back('{ADDR_NEW_COEFF, 1'b0, 16'h0, 1'b0, s + 7 + 2 * i});
    last = s + 7 + 2 * (nr - 1);
    finish_seq(seq, e, '{2, 16'h0, 1'b0, last + 2}, to, last + 2, end_c);
    @(posedge clk); #1;
    coeff_start = 1'b0;
    wait_idle(end_c, "coeff_done_cycle");
  endtask

  task automatic run_sample(input logic [15:0] d, input int b,
                            input logic er, input logic [15:0] r,
                            input int e, input bit pre, output int h);
    xfer_t seq[$];
    int    nr, last, end_c;
    bit    to, ok;
    h = -1;
    if (!pre) begin
      @(posedge clk); #1;
      sample_data  = d;
      sample_valid = 1'b1;
      @(negedge clk);
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sample_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("sample_handshake", ok, ok, 1);
    if (!ok) begin
      sample_valid = 1'b0;
      return;
    end
    h       = cyc;
    st_left = b;
    st_err  = er;
    res_val = r;
    err_at  = (e < 0) ? -1 : tot + e;
    seq.push_back('{ADDR_SAMPLE, 1'b1, d, 1'b1, h + 1});
    nr = b + 1;
    to = 1'b0;
`ifdef AHB_MASTER_POLL_TIMEOUT_EN
    if (b >= PM) begin
      nr = PM;
      to = 1'b1;
    end
`endif
    for (int i = 0; i < nr; i++)
      seq.push_back('{ADDR_STATUS, 1'b0, 16'h0, 1'b0, h + 3 + 2 * i});
    last = h + 3 + 2 * (nr - 1);
    if (to) begin
      finish_seq(seq, e, '{2, 16'h0, 1'b0, last + 2}, 1'b1,
                 last + 2, end_c);
    end else begin
      seq.push_back('{ADDR_RESULT, 1'b0, 16'h0, 1'b0, last + 2});
      finish_seq(seq, e, '{0, r, er, last + 4}, 1'b1, last + 4, end_c);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    wait_idle(end_c, "sample_done_cycle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [46:0] ov;
  int          ec, h, k, b, e;
  logic [63:0] rc;

  initial begin
    #2;
    ov = {busy, hsel, htrans, haddr, hwrite, hsize, hwdata, result_valid,
          result_data, result_err, bus_err, timeout, sample_ready};
    chk("reset_outputs", ov == '0, ov, 0);
    #10;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    run_coeff(64'h0004_0003_0002_0001, 3, -1, 1'b0, ec);
    run_sample(16'h0100, 2, 1'b0, 16'h0400, -1, 1'b0, h);
    run_sample(16'h0055, 0, 1'b1, 16'h7777, -1, 1'b0, h);
    run_coeff(64'h1111_2222_3333_4444, 2, 1, 1'b0, ec);
    chk("idle_after_bus_err", busy == 1'b0, busy, 0);

    sample_data = 16'h0A0A;
    run_coeff(64'hAAAA_BBBB_CCCC_DDDD, 1, -1, 1'b1, ec);
    run_sample(16'h0A0A, 1, 1'b0, 16'h1234, -1, 1'b1, h);
    chk("sample_after_coeff", h == ec, h, ec);

`ifdef AHB_MASTER_POLL_TIMEOUT_EN
    run_sample(16'h0BAD, 10, 1'b0, 16'h5555, -1, 1'b0, h);
    run_coeff(64'h0123_4567_89AB_CDEF, 10, -1, 1'b0, ec);
`endif

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 2) == 0) begin
        rc = {$urandom, $urandom};
        k  = $urandom_range(0, 5);
        e  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
        run_coeff(rc, k, e, 1'b0, ec);
      end else begin
        b = $urandom_range(0, 5);
        e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
        run_sample(16'($urandom), b, 1'($urandom), 16'($urandom),
                   e, 1'b0, h);
      end
    end

    sb_off  = 1'b1;
    err_at  = -1;
    st_left = 50;
    @(posedge clk); #1;
    sample_data  = 16'h1234;
    sample_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    ov = {busy, hsel, htrans, haddr, hwrite, hsize, hwdata, result_valid,
          result_data, result_err, bus_err, timeout, sample_ready};
    chk("async_reset_outputs", ov == '0, ov, 0);
    @(negedge clk);
    exp_x.delete();
    exp_ev.delete();
    st_left = 0;
    @(posedge clk); #2;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    sb_off = 1'b0;
    run_sample(16'h4321, 1, 1'b0, 16'h0F0F, -1, 1'b0, h);

    repeat (5) @(posedge clk);
    chk("xfer_queue_empty", exp_x.size() == 0, exp_x.size(), 0);
    chk("event_queue_empty", exp_ev.size() == 0, exp_ev.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
